// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared main-memory port.
// Requester 0 is the I-cache refill path, requester 1 the D-cache
// refill/write-back path. One transaction is outstanding at a time. A
// watchdog ends a transaction that memory never acknowledges and flags it
// with an error.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    output logic                  o_done0,
    output logic                  o_done1,
    output logic                  o_err0,
    output logic                  o_err1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_sel,
    output logic                  o_busy,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    // The counter must hold TIMEOUT-1. When the watchdog is disabled, it
    // keeps one bit so that the logic stays legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_last;
    logic                  r_sel;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_memReq;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic                  r_memWe;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done0;
    logic                  r_done1;
    logic                  r_err0;
    logic                  r_err1;

    logic                  w_grant;
    logic                  w_winner;
    logic                  w_ack;
    logic                  w_expire;

    // Next-state logic. An acknowledge has priority over watchdog expiry.
    // The DONE state never grants, so a requester's stale request is not
    // served twice.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_winner    = 1'b0;
        w_ack       = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    w_grant     = 1'b1;
                    w_winner    = (i_req0 && i_req1) ? ~r_last : i_req1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    w_ack       = 1'b1;
                    w_nextState = DONE;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
                    w_expire    = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath registers. Memory-side outputs are captured on grant and held
    // for the whole transaction. Done and err pulse for the one DONE cycle.
    // Read data persists until the next completion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_cnt      <= '0;
            r_memReq   <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWe    <= 1'b0;
            r_rdata    <= '0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            if (w_grant) begin
                r_sel      <= w_winner;
                r_last     <= w_winner;
                r_memAddr  <= w_winner ? i_addr1  : i_addr0;
                r_memWdata <= w_winner ? i_wdata1 : i_wdata0;
                r_memWe    <= w_winner ? i_we1    : i_we0;
                r_cnt      <= '0;
                r_memReq   <= 1'b1;
            end else if (w_ack) begin
                r_rdata  <= i_mem_rdata;
                r_done0  <= ~r_sel;
                r_done1  <= r_sel;
                r_memReq <= 1'b0;
            end else if (w_expire) begin
                r_rdata  <= '0;
                r_done0  <= ~r_sel;
                r_done1  <= r_sel;
                r_err0   <= ~r_sel;
                r_err1   <= r_sel;
                r_memReq <= 1'b0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy      = (r_state == BUSY);
    assign o_mem_req   = r_memReq;
    assign o_sel       = r_sel;
    assign o_mem_addr  = r_memAddr;
    assign o_mem_wdata = r_memWdata;
    assign o_mem_we    = r_memWe;
    assign o_rdata     = r_rdata;
    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_err0      = r_err0;
    assign o_err1      = r_err1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. The reference model is transaction-level.
// It picks the round-robin winner from the pending requests. It decides
// whether the ack comes before the watchdog, and from that it derives the
// cycle count, the error flag and the read data for every transaction.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_req0, i_req1;
    logic [AW-1:0] i_addr0, i_addr1;
    logic [DW-1:0] i_wdata0, i_wdata1;
    logic          i_we0, i_we1;
    logic          o_done0, o_done1, o_err0, o_err1;
    logic [DW-1:0] o_rdata;
    logic          o_sel, o_busy, o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          o_mem_we;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;

    int assertCount = 0;
    int failCount   = 0;

    logic          reqOn    [2];
    logic [AW-1:0] reqAddr  [2];
    logic [DW-1:0] reqWdata [2];
    logic          reqWe    [2];
    int            lastWinner;
    logic [DW-1:0] lastRdata;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_addr0(i_addr0), .i_addr1(i_addr1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .i_we0(i_we0), .i_we1(i_we1),
        .o_done0(o_done0), .o_done1(o_done1),
        .o_err0(o_err0), .o_err1(o_err1),
        .o_rdata(o_rdata), .o_sel(o_sel), .o_busy(o_busy),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    // Free-running clock with a 10-unit period.
    always #5 i_clk = ~i_clk;

    // Hard time limit so the run always ends on its own.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

    // One comparison: count it, and on mismatch count the failure and report it.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the requester-side inputs from the request table.
    task automatic applyStimulus();
        i_req0   = reqOn[0];
        i_req1   = reqOn[1];
        i_addr0  = reqAddr[0];
        i_addr1  = reqAddr[1];
        i_wdata0 = reqWdata[0];
        i_wdata1 = reqWdata[1];
        i_we0    = reqWe[0];
        i_we1    = reqWe[1];
    endtask

    task automatic newPayload(input int r);
        reqAddr[r]  = $urandom;
        reqWdata[r] = $urandom;
        reqWe[r]    = 1'($urandom_range(0, 1));
    endtask

    // One full transaction, starting at a negedge with the DUT in IDLE.
    // ackAt is the BUSY cycle (1-based) in which memory acks; 0 means never.
    task automatic runTxn(input int ackAt, input logic [DW-1:0] ackData,
                          input bit dropMid, input bit strayAck);
        int            winner;
        bit            expErr;
        int            finishAt;
        logic [DW-1:0] expRdata;
        logic [AW-1:0] expAddr;
        applyStimulus();
        if (reqOn[0] && reqOn[1]) winner = 1 - lastWinner;
        else                      winner = reqOn[1] ? 1 : 0;
        expErr   = !(ackAt >= 1 && ackAt <= TO);
        finishAt = expErr ? TO : ackAt;
        expRdata = expErr ? '0 : ackData;
        expAddr  = reqAddr[winner];
        @(negedge i_clk);
        lastWinner = winner;
        checkOutput("grantSel",   o_sel, winner);
        checkOutput("grantReq",   o_mem_req, 1);
        checkOutput("grantBusy",  o_busy, 1);
        checkOutput("grantAddr",  o_mem_addr, expAddr);
        checkOutput("grantWe",    o_mem_we, reqWe[winner]);
        checkOutput("grantWdata", o_mem_wdata, reqWdata[winner]);
        for (int c = 1; c <= finishAt; c++) begin
            if (c == ackAt) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = ackData;
            end
            if (dropMid && c == 1) begin
                reqOn[winner] = 1'b0;
                applyStimulus();
            end
            @(negedge i_clk);
            i_mem_ack   = 1'b0;
            i_mem_rdata = $urandom;
            if (c < finishAt) begin
                checkOutput("busyReq",   o_mem_req, 1);
                checkOutput("busyDone",  {o_done0, o_done1}, 2'b00);
                checkOutput("busyAddr",  o_mem_addr, expAddr);
            end
        end
        checkOutput("doneOwner", winner == 0 ? o_done0 : o_done1, 1);
        checkOutput("doneOther", winner == 0 ? o_done1 : o_done0, 0);
        checkOutput("errOwner",  winner == 0 ? o_err0 : o_err1, expErr);
        checkOutput("errOther",  winner == 0 ? o_err1 : o_err0, 0);
        checkOutput("doneRdata", o_rdata, expRdata);
        checkOutput("doneReq",   o_mem_req, 0);
        checkOutput("doneBusy",  o_busy, 0);
        lastRdata     = expRdata;
        reqOn[winner] = 1'b0;
        applyStimulus();
        if (strayAck) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = $urandom;
        end
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        checkOutput("idleDone",  {o_done0, o_done1, o_err0, o_err1}, 4'b0000);
        checkOutput("idleReq",   o_mem_req, 0);
        checkOutput("idleBusy",  o_busy, 0);
        checkOutput("idleRdata", o_rdata, lastRdata);
    endtask

    // Directed sequence first, then randomized traffic.
    initial begin
        i_rst       = 1'b1;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        for (int r = 0; r < 2; r++) begin
            reqOn[r]    = 1'b0;
            reqAddr[r]  = '0;
            reqWdata[r] = '0;
            reqWe[r]    = 1'b0;
        end
        applyStimulus();
        lastWinner = 1;
        lastRdata  = '0;

        // Reset state.
        @(negedge i_clk);
        @(negedge i_clk);
        checkOutput("rstOutputs", {o_done0, o_done1, o_err0, o_err1, o_sel, o_busy, o_mem_req, o_mem_we}, 8'h00);
        checkOutput("rstRdata", o_rdata, 0);
        checkOutput("rstAddr",  o_mem_addr, 0);
        i_rst = 1'b0;

        // Stray ack while IDLE is ignored.
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hFFFF_0000;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        checkOutput("strayIdle", {o_done0, o_done1, o_busy, o_mem_req}, 4'b0000);
        checkOutput("strayIdleRdata", o_rdata, 0);

        // Reset in the middle of a requester-1 transaction.
        reqOn[1] = 1'b1; reqAddr[1] = 32'h0000_3000; reqWe[1] = 1'b0;
        applyStimulus();
        @(negedge i_clk);
        checkOutput("preRstSel", o_sel, 1);
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        checkOutput("midRstReq",  o_mem_req, 0);
        checkOutput("midRstBusy", o_busy, 0);
        checkOutput("midRstSel",  o_sel, 0);
        checkOutput("midRstDone", {o_done0, o_done1}, 2'b00);
        reqOn[1] = 1'b0;
        applyStimulus();
        lastWinner = 1;
        @(negedge i_clk);
        i_rst = 1'b0;

        // Single read by requester 0, ack in the third BUSY cycle.
        reqOn[0] = 1'b1; reqAddr[0] = 32'h0000_1000; reqWdata[0] = '0; reqWe[0] = 1'b0;
        runTxn(3, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Reset in IDLE restores the pointer, so the first tie goes to requester 0.
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        lastWinner = 1;
        checkOutput("rstIdleRdata", o_rdata, 0);
        lastRdata = '0;

        // Contention: both requesters keep requesting. Grants alternate.
        reqOn[0] = 1'b1; newPayload(0);
        reqOn[1] = 1'b1; newPayload(1);
        for (int n = 0; n < 4; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!reqOn[r]) begin
                    reqOn[r] = 1'b1;
                    newPayload(r);
                end
            end
            runTxn(2, $urandom, 1'b0, 1'b0);
        end
        // Drain the pending request left over from contention.
        for (int r = 0; r < 2; r++) begin
            if (reqOn[r]) runTxn(1, $urandom, 1'b0, 1'b0);
        end

        // Write by requester 1 with immediate ack (done two edges after the request).
        reqOn[1] = 1'b1; reqAddr[1] = 32'h0000_2000; reqWdata[1] = 32'h1234_5678; reqWe[1] = 1'b1;
        runTxn(1, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Watchdog expiry with no ack, then ack in the last cycle, which wins.
        reqOn[0] = 1'b1; newPayload(0);
        runTxn(0, 32'h5555_AAAA, 1'b0, 1'b1);
        reqOn[0] = 1'b1; newPayload(0);
        runTxn(TO, 32'hCAFE_0001, 1'b0, 1'b0);

        // Request dropped mid-transaction still completes.
        reqOn[1] = 1'b1; newPayload(1);
        runTxn(2, 32'h7777_8888, 1'b1, 1'b0);

        // Randomized traffic. A losing request stays pending until it is served.
        for (int t = 0; t < 60; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!reqOn[r] && $urandom_range(0, 1) == 1) begin
                    reqOn[r] = 1'b1;
                    newPayload(r);
                end
            end
            if (!reqOn[0] && !reqOn[1]) begin
                reqOn[0] = 1'b1;
                newPayload(0);
            end
            runTxn(int'($urandom_range(0, TO + 2)), $urandom,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
